// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions for the ID/EX pipeline register: widths, ALU op
// encodings, the control bundle and the full stage payload.
package id_ex_stage_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned ALUOP_W    = 2;
    localparam int unsigned FUNCT_W    = 10;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        logic   mem_to_reg;
        logic   alu_src;
        aluop_e alu_op;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        ctrl_t                 ctrl;
        logic [FUNCT_W-1:0]    funct;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
    } id_ex_t;

    // A bubble is an all-zero payload: no writes, no memory access, RD = x0.
    localparam id_ex_t ID_EX_BUBBLE = '0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction currently in ID. Writes to x0 never create a hazard.
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    output logic                  hazard_o
);

    logic rd_nonzero;
    logic rd_match;

    assign rd_nonzero = (ex_rd_i != '0);
    assign rd_match   = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);
    assign hazard_o   = ex_mem_read_i && rd_nonzero && rd_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, flush squashing and a
// saturating count of inserted bubbles.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [REG_ADDR_W-1:0] IF_ID_RS1_i,
    input  logic [REG_ADDR_W-1:0] IF_ID_RS2_i,
    input  logic [REG_ADDR_W-1:0] IF_ID_RD_i,
    input  logic                  RegWrite_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic                  MemtoReg_i,
    input  logic                  ALUSrc_i,
    input  logic [ALUOP_W-1:0]    ALUOp_i,
    input  logic [FUNCT_W-1:0]    funct_i,
    input  logic [XLEN-1:0]       RS1data_i,
    input  logic [XLEN-1:0]       RS2data_i,
    input  logic [XLEN-1:0]       Imm_i,
    output logic [REG_ADDR_W-1:0] ID_EX_RS1_o,
    output logic [REG_ADDR_W-1:0] ID_EX_RS2_o,
    output logic [REG_ADDR_W-1:0] ID_EX_RD_o,
    output logic                  ID_EX_RegWrite_o,
    output logic                  ID_EX_MemRead_o,
    output logic                  ID_EX_MemWrite_o,
    output logic                  ID_EX_MemtoReg_o,
    output logic                  ID_EX_ALUSrc_o,
    output logic [ALUOP_W-1:0]    ID_EX_ALUOp_o,
    output logic [FUNCT_W-1:0]    ID_EX_funct_o,
    output logic [XLEN-1:0]       ID_EX_RS1data_o,
    output logic [XLEN-1:0]       ID_EX_RS2data_o,
    output logic [XLEN-1:0]       ID_EX_Imm_o,
    output logic                  PCWrite_o,
    output logic                  IF_ID_Write_o,
    output logic                  Bubble_o,
    output logic [CNT_W-1:0]      StallCnt_o
);

    id_ex_t            id_ex_q;
    id_ex_t            id_ex_d;
    id_ex_t            id_in;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic              hazard;
    logic              bubble;

    id_ex_stage_hazard_detect hazard_detect (
        .ex_mem_read_i (id_ex_q.ctrl.mem_read),
        .ex_rd_i       (id_ex_q.rd),
        .id_rs1_i      (IF_ID_RS1_i),
        .id_rs2_i      (IF_ID_RS2_i),
        .hazard_o      (hazard)
    );

    // Gather the decoded ID fields into one payload.
    always_comb begin
        id_in                 = ID_EX_BUBBLE;
        id_in.rs1             = IF_ID_RS1_i;
        id_in.rs2             = IF_ID_RS2_i;
        id_in.rd              = IF_ID_RD_i;
        id_in.ctrl.reg_write  = RegWrite_i;
        id_in.ctrl.mem_read   = MemRead_i;
        id_in.ctrl.mem_write  = MemWrite_i;
        id_in.ctrl.mem_to_reg = MemtoReg_i;
        id_in.ctrl.alu_src    = ALUSrc_i;
        id_in.ctrl.alu_op     = aluop_e'(ALUOp_i);
        id_in.funct           = funct_i;
        id_in.rs1_data        = RS1data_i;
        id_in.rs2_data        = RS2data_i;
        id_in.imm             = Imm_i;
    end

    // Front-end freeze and bubble strobe are combinational so the PC and
    // IF/ID register see them in the same cycle the hazard appears.
    assign bubble        = !stall_i && (flush_i || hazard);
    assign PCWrite_o     = !(hazard || stall_i);
    assign IF_ID_Write_o = !(hazard || stall_i);
    assign Bubble_o      = bubble;

    // Priority: back-pressure holds, then flush/hazard squash, else load.
    always_comb begin
        id_ex_d     = id_ex_q;
        stall_cnt_d = stall_cnt_q;
        if (!stall_i) begin
            if (bubble) begin
                id_ex_d     = ID_EX_BUBBLE;
                stall_cnt_d = sat_inc(stall_cnt_q);
            end else begin
                id_ex_d     = id_in;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            id_ex_q     <= ID_EX_BUBBLE;
            stall_cnt_q <= '0;
        end else begin
            id_ex_q     <= id_ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ID_EX_RS1_o      = id_ex_q.rs1;
    assign ID_EX_RS2_o      = id_ex_q.rs2;
    assign ID_EX_RD_o       = id_ex_q.rd;
    assign ID_EX_RegWrite_o = id_ex_q.ctrl.reg_write;
    assign ID_EX_MemRead_o  = id_ex_q.ctrl.mem_read;
    assign ID_EX_MemWrite_o = id_ex_q.ctrl.mem_write;
    assign ID_EX_MemtoReg_o = id_ex_q.ctrl.mem_to_reg;
    assign ID_EX_ALUSrc_o   = id_ex_q.ctrl.alu_src;
    assign ID_EX_ALUOp_o    = id_ex_q.ctrl.alu_op;
    assign ID_EX_funct_o    = id_ex_q.funct;
    assign ID_EX_RS1data_o  = id_ex_q.rs1_data;
    assign ID_EX_RS2data_o  = id_ex_q.rs2_data;
    assign ID_EX_Imm_o      = id_ex_q.imm;
    assign StallCnt_o       = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage: per-cycle vectors with hand-derived
// expectations, a queue of expected stage contents, and corner sequences.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [4:0]  IF_ID_RS1_i, IF_ID_RS2_i, IF_ID_RD_i;
    logic        RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUSrc_i;
    logic [1:0]  ALUOp_i;
    logic [9:0]  funct_i;
    logic [31:0] RS1data_i, RS2data_i, Imm_i;
    logic [4:0]  ID_EX_RS1_o, ID_EX_RS2_o, ID_EX_RD_o;
    logic        ID_EX_RegWrite_o, ID_EX_MemRead_o, ID_EX_MemWrite_o;
    logic        ID_EX_MemtoReg_o, ID_EX_ALUSrc_o;
    logic [1:0]  ID_EX_ALUOp_o;
    logic [9:0]  ID_EX_funct_o;
    logic [31:0] ID_EX_RS1data_o, ID_EX_RS2data_o, ID_EX_Imm_o;
    logic        PCWrite_o, IF_ID_Write_o, Bubble_o;
    logic [15:0] StallCnt_o;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .IF_ID_RS1_i(IF_ID_RS1_i), .IF_ID_RS2_i(IF_ID_RS2_i), .IF_ID_RD_i(IF_ID_RD_i),
        .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .MemtoReg_i(MemtoReg_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
        .funct_i(funct_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i),
        .ID_EX_RS1_o(ID_EX_RS1_o), .ID_EX_RS2_o(ID_EX_RS2_o), .ID_EX_RD_o(ID_EX_RD_o),
        .ID_EX_RegWrite_o(ID_EX_RegWrite_o), .ID_EX_MemRead_o(ID_EX_MemRead_o),
        .ID_EX_MemWrite_o(ID_EX_MemWrite_o), .ID_EX_MemtoReg_o(ID_EX_MemtoReg_o),
        .ID_EX_ALUSrc_o(ID_EX_ALUSrc_o), .ID_EX_ALUOp_o(ID_EX_ALUOp_o),
        .ID_EX_funct_o(ID_EX_funct_o), .ID_EX_RS1data_o(ID_EX_RS1data_o),
        .ID_EX_RS2data_o(ID_EX_RS2data_o), .ID_EX_Imm_o(ID_EX_Imm_o),
        .PCWrite_o(PCWrite_o), .IF_ID_Write_o(IF_ID_Write_o), .Bubble_o(Bubble_o),
        .StallCnt_o(StallCnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic        regw, memr, memw, m2r, alusrc;
        logic [1:0]  aluop;
        logic [9:0]  funct;
        logic [31:0] rs1d, rs2d, imm;
    } stage_t;

    localparam int K_LOAD = 0;
    localparam int K_BUB  = 1;
    localparam int K_HOLD = 2;

    typedef struct {
        logic        stall, flush;
        logic [4:0]  rs1, rs2, rd;
        logic        regw, memr, memw;
        int          kind;
        logic        exp_pcw, exp_bub;
        logic [15:0] exp_cnt;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    stage_t exp_state;
    stage_t exp_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic stage_t dut_out();
        return {ID_EX_RS1_o, ID_EX_RS2_o, ID_EX_RD_o, ID_EX_RegWrite_o, ID_EX_MemRead_o,
                ID_EX_MemWrite_o, ID_EX_MemtoReg_o, ID_EX_ALUSrc_o, ID_EX_ALUOp_o,
                ID_EX_funct_o, ID_EX_RS1data_o, ID_EX_RS2data_o, ID_EX_Imm_o};
    endfunction

    task automatic drive(input stage_t s);
        IF_ID_RS1_i = s.rs1;   IF_ID_RS2_i = s.rs2;   IF_ID_RD_i = s.rd;
        RegWrite_i  = s.regw;  MemRead_i   = s.memr;  MemWrite_i = s.memw;
        MemtoReg_i  = s.m2r;   ALUSrc_i    = s.alusrc; ALUOp_i   = s.aluop;
        funct_i     = s.funct; RS1data_i   = s.rs1d;  RS2data_i  = s.rs2d;
        Imm_i       = s.imm;
    endtask

    function automatic vec_t mk(input logic st, input logic fl, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] rd, input logic rw,
                                input logic mr, input logic mw, input int k,
                                input logic pcw, input logic bub, input logic [15:0] cnt);
        vec_t v;
        v.stall = st; v.flush = fl; v.rs1 = r1; v.rs2 = r2; v.rd = rd;
        v.regw = rw; v.memr = mr; v.memw = mw; v.kind = k;
        v.exp_pcw = pcw; v.exp_bub = bub; v.exp_cnt = cnt;
        return v;
    endfunction

    initial begin
        vec_t   tv[17];
        stage_t s;
        stage_t got;

        //          st  fl  rs1 rs2 rd  rw  mr  mw  kind    pcw bub cnt
        tv[0]  = mk(0,  0,  1,  2,  3,  1,  0,  0,  K_LOAD, 1,  0,  0); // add x3,x1,x2
        tv[1]  = mk(0,  0,  1,  0,  5,  1,  1,  0,  K_LOAD, 1,  0,  0); // lw x5
        tv[2]  = mk(0,  0,  5,  2,  6,  1,  0,  0,  K_BUB,  0,  1,  1); // use of x5
        tv[3]  = mk(0,  0,  5,  2,  6,  1,  0,  0,  K_LOAD, 1,  0,  1);
        tv[4]  = mk(0,  0,  1,  0,  0,  1,  1,  0,  K_LOAD, 1,  0,  1); // lw x0
        tv[5]  = mk(0,  0,  1,  0,  7,  1,  0,  0,  K_LOAD, 1,  0,  1); // reads x0
        tv[6]  = mk(0,  0,  2,  0,  8,  1,  1,  0,  K_LOAD, 1,  0,  1); // lw x8
        tv[7]  = mk(1,  0,  3,  8,  9,  1,  0,  0,  K_HOLD, 0,  0,  1); // stall+hazard
        tv[8]  = mk(1,  0,  3,  8,  9,  1,  0,  0,  K_HOLD, 0,  0,  1);
        tv[9]  = mk(1,  0,  3,  8,  9,  1,  0,  0,  K_HOLD, 0,  0,  1);
        tv[10] = mk(0,  0,  3,  8,  9,  1,  0,  0,  K_BUB,  0,  1,  2);
        tv[11] = mk(0,  0,  3,  8,  9,  1,  0,  0,  K_LOAD, 1,  0,  2);
        tv[12] = mk(0,  0,  1,  0,  10, 1,  1,  0,  K_LOAD, 1,  0,  2); // lw x10
        tv[13] = mk(0,  1,  2,  10, 0,  0,  0,  1,  K_BUB,  0,  1,  3); // flush+hazard
        tv[14] = mk(0,  1,  2,  10, 0,  0,  0,  1,  K_BUB,  1,  1,  4); // flush sw
        tv[15] = mk(1,  1,  1,  2,  11, 1,  0,  0,  K_HOLD, 0,  0,  4); // stall wins
        tv[16] = mk(0,  0,  1,  2,  11, 1,  0,  0,  K_LOAD, 1,  0,  4);

        drive('0);
        #12;
        chk("reset_stage", 128'(dut_out()), 128'(0));
        chk("reset_cnt", 128'(StallCnt_o), 128'(0));
        chk("reset_pcwrite", 128'({PCWrite_o, IF_ID_Write_o, Bubble_o}), 128'(3'b110));

        @(negedge clk_i);
        rst_i = 1'b1;
        exp_state = '0;

        for (int i = 0; i < 17; i++) begin
            s.rs1 = tv[i].rs1; s.rs2 = tv[i].rs2; s.rd = tv[i].rd;
            s.regw = tv[i].regw; s.memr = tv[i].memr; s.memw = tv[i].memw;
            s.m2r = tv[i].memr; s.alusrc = tv[i].memr | tv[i].memw;
            s.aluop = 2'(i);
            s.funct = 10'(i * 37);
            s.rs1d  = 32'h1000_0000 + 32'(i);
            s.rs2d  = 32'h2000_0000 + 32'(i);
            s.imm   = 32'hFFFF_F000 | 32'(i);
            stall_i = tv[i].stall;
            flush_i = tv[i].flush;
            drive(s);
            #1;
            chk($sformatf("v%0d_pcwrite", i), 128'(PCWrite_o), 128'(tv[i].exp_pcw));
            chk($sformatf("v%0d_ifidwrite", i), 128'(IF_ID_Write_o), 128'(tv[i].exp_pcw));
            chk($sformatf("v%0d_bubble", i), 128'(Bubble_o), 128'(tv[i].exp_bub));
            if (tv[i].kind == K_LOAD) exp_state = s;
            else if (tv[i].kind == K_BUB) exp_state = '0;
            exp_q.push_back(exp_state);
            @(posedge clk_i);
            #1;
            got = exp_q.pop_front();
            chk($sformatf("v%0d_stage", i), 128'(dut_out()), 128'(got));
            chk($sformatf("v%0d_cnt", i), 128'(StallCnt_o), 128'(tv[i].exp_cnt));
            @(negedge clk_i);
        end

        // Asynchronous reset in the middle of a cycle with a live instruction.
        stall_i = 1'b0; flush_i = 1'b0;
        s = '0; s.rs1 = 5'd1; s.rs2 = 5'd2; s.rd = 5'd12; s.regw = 1'b1; s.rs1d = 32'hCAFE_0001;
        drive(s);
        @(posedge clk_i);
        #1;
        chk("pre_reset_regwrite", 128'(ID_EX_RegWrite_o), 128'(1));
        #2;
        rst_i = 1'b0;
        #1;
        chk("async_reset_stage", 128'(dut_out()), 128'(0));
        chk("async_reset_cnt", 128'(StallCnt_o), 128'(0));
        chk("async_reset_flags", 128'({PCWrite_o, IF_ID_Write_o, Bubble_o}), 128'(3'b110));
        @(negedge clk_i);
        rst_i = 1'b1;

        // Counter saturation under a long run of flushes of a store.
        s = '0; s.rs1 = 5'd2; s.rs2 = 5'd10; s.memw = 1'b1; s.alusrc = 1'b1;
        drive(s);
        flush_i = 1'b1;
        #1;
        chk("flush_bubble", 128'(Bubble_o), 128'(1));
        repeat (65534) @(posedge clk_i);
        #1;
        chk("cnt_fffe", 128'(StallCnt_o), 128'(16'hFFFE));
        @(posedge clk_i);
        #1;
        chk("cnt_ffff", 128'(StallCnt_o), 128'(16'hFFFF));
        @(posedge clk_i);
        #1;
        chk("cnt_saturated", 128'(StallCnt_o), 128'(16'hFFFF));
        chk("flush_ctrl", 128'({ID_EX_MemWrite_o, ID_EX_RegWrite_o}), 128'(2'b00));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
